// File: rtl/mux_n_1_pkg.sv
// Shared definitions for the N:1 registered multiplexer with round-robin
// arbitration: mode encodings and the select-width helper.
package mux_n_1_pkg;

   localparam logic MODE_SEL = 1'b0;  // fixed select by sel
   localparam logic MODE_RR  = 1'b1;  // round-robin arbitration

   // Width of a channel index; never narrower than one bit.
   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or above ptr_i, wrapping from
// N_CH-1 back to 0. The grant is one-hot, or all-zero when nothing requests.
module rr_arbiter
   import mux_n_1_pkg::*;
#(
   parameter int N_CH = 4,
   localparam int SEL_W = sel_w(N_CH)
) (
   input  logic [N_CH-1:0]  req_i,
   input  logic [SEL_W-1:0] ptr_i,
   output logic [N_CH-1:0]  gnt_o
);

   logic [2*N_CH-1:0] req_dbl;
   logic [N_CH-1:0]   req_rot;
   logic [SEL_W:0]    offs;
   logic [SEL_W:0]    pos;

   // Rotate requests so ptr_i sits at bit 0, take the lowest set bit, and
   // rotate that position back into the channel index space.
   always_comb begin
      req_dbl = {req_i, req_i} >> ptr_i;
      req_rot = req_dbl[N_CH-1:0];
      offs    = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (req_rot[i]) offs = (SEL_W+1)'(i);
      end
      pos = {1'b0, ptr_i} + offs;
      if (pos >= (SEL_W+1)'(N_CH)) pos = pos - (SEL_W+1)'(N_CH);
      gnt_o = (|req_rot) ? (N_CH'(1) << pos) : '0;
   end

endmodule

// File: rtl/mux_n_1_rr.sv
// N:1 multiplexer with a single registered output stage. Mode 0 forwards the
// channel chosen by sel; mode 1 arbitrates round-robin among valid channels.
// Optional feature macro: MUX_N_1_RR_PKT_LOCK_EN adds in_last and keeps a
// round-robin grant on one channel until the last beat of its packet.
//
// Handshake: a word moves across an interface on a rising clk edge where both
// valid and ready are high. Valid may not depend on ready. Input side:
// in_ready[k] is high only for the granted channel and only when the output
// register is empty or being popped (load). Output side: out_valid/out_data/
// out_ch stay stable until out_ready is seen high.
module mux_n_1_rr
   import mux_n_1_pkg::*;
#(
   parameter int N_CH   = 4,
   parameter int DATA_W = 8,
   localparam int SEL_W = sel_w(N_CH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   mode,
   input  logic [SEL_W-1:0]       sel,
   input  logic [N_CH-1:0]        in_valid,
   input  logic [N_CH*DATA_W-1:0] in_data,
`ifdef MUX_N_1_RR_PKT_LOCK_EN
   input  logic [N_CH-1:0]        in_last,
`endif
   output logic [N_CH-1:0]        in_ready,
   output logic                   out_valid,
   output logic [DATA_W-1:0]      out_data,
   output logic [SEL_W-1:0]       out_ch,
   input  logic                   out_ready
);

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
   logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;
`ifdef MUX_N_1_RR_PKT_LOCK_EN
   logic              lock_q,      lock_d;
   logic [SEL_W-1:0]  lock_ch_q,   lock_ch_d;
`endif

   logic              load;
   logic              xfer;
   logic [N_CH-1:0]   arb_gnt;
   logic [N_CH-1:0]   gnt;
   logic [SEL_W-1:0]  gnt_idx;
   logic [DATA_W-1:0] gnt_data;
   logic [SEL_W-1:0]  next_ptr;

   rr_arbiter #(.N_CH(N_CH)) u_arb (
      .req_i (in_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (arb_gnt)
   );

   assign load = !out_valid_q || out_ready;
   assign xfer = |(in_valid & in_ready);

   // Pick the granted channel for the current mode and gate it with load.
   // In fixed mode an out-of-range sel shifts the bit off the vector, so no
   // channel is granted.
   always_comb begin
      if (mode == MODE_RR) begin
`ifdef MUX_N_1_RR_PKT_LOCK_EN
         gnt = lock_q ? (in_valid & (N_CH'(1) << lock_ch_q)) : arb_gnt;
`else
         gnt = arb_gnt;
`endif
      end else begin
         gnt = in_valid & (N_CH'(1) << sel);
      end
      in_ready = (rst_n && load) ? gnt : '0;
   end

   // Turn the one-hot grant into a channel index and its payload.
   always_comb begin
      gnt_idx  = '0;
      gnt_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (gnt[i]) begin
            gnt_idx  = SEL_W'(i);
            gnt_data = in_data[i*DATA_W +: DATA_W];
         end
      end
      next_ptr = (gnt_idx == SEL_W'(N_CH - 1)) ? '0 : gnt_idx + SEL_W'(1);
   end

   // Next state of the output register, the round-robin pointer and the lock.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      rr_ptr_d    = rr_ptr_q;
`ifdef MUX_N_1_RR_PKT_LOCK_EN
      lock_d      = lock_q;
      lock_ch_d   = lock_ch_q;
`endif
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = gnt_data;
         out_ch_d    = gnt_idx;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (xfer && mode == MODE_RR) begin
`ifdef MUX_N_1_RR_PKT_LOCK_EN
         if (|(in_last & gnt)) begin
            rr_ptr_d = next_ptr;
            lock_d   = 1'b0;
         end else begin
            lock_d    = 1'b1;
            lock_ch_d = gnt_idx;
         end
`else
         rr_ptr_d = next_ptr;
`endif
      end
   end

   // State registers; reset empties the output stage and rewinds the pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         rr_ptr_q    <= '0;
`ifdef MUX_N_1_RR_PKT_LOCK_EN
         lock_q      <= 1'b0;
         lock_ch_q   <= '0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         rr_ptr_q    <= rr_ptr_d;
`ifdef MUX_N_1_RR_PKT_LOCK_EN
         lock_q      <= lock_d;
         lock_ch_q   <= lock_ch_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_n_1_rr.sv
// Bench for mux_n_1_rr: directed scenarios plus a randomized run scored
// against a word-level reference model. MUX_N_1_RR_PKT_LOCK_EN enables the
// packet-lock scenario and model.
module tb_mux_n_1_rr;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int SW = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           mode;
   logic [SW-1:0]  sel;
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
`ifdef MUX_N_1_RR_PKT_LOCK_EN
   logic [N-1:0]   in_last;
`endif
   logic [N-1:0]   in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [SW-1:0]  out_ch;
   logic           out_ready;

   int checks = 0;
   int errors = 0;

   // Scoreboard: words expected in the output register, {channel, data}.
   logic [SW+W-1:0] exp_q[$];
   // Model arbitration state: next channel to favour and packet lock.
   int m_ptr;
   bit m_lock;
   int m_lock_ch;

   mux_n_1_rr #(.N_CH(N), .DATA_W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
`ifdef MUX_N_1_RR_PKT_LOCK_EN
      .in_last   (in_last),
`endif
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_ready (out_ready)
   );

   // Clock / reset block
   always #5 clk = ~clk;

   task automatic idle_inputs();
      mode      = 1'b0;
      sel       = '0;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;
`ifdef MUX_N_1_RR_PKT_LOCK_EN
      in_last   = '1;
`endif
   endtask

   task automatic ramp_data();
      for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(8'hA0 + k);
   endtask

   // Ends one time unit after a rising edge, the point where inputs are driven.
   task automatic apply_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      m_ptr     = 0;
      m_lock    = 0;
      m_lock_ch = 0;
      exp_q.delete();
   endtask

   // Reference: which channel the rules grant now, or -1.
   function automatic int model_grant();
      if (mode == 1'b0) return in_valid[sel] ? int'(sel) : -1;
      if (m_lock) return in_valid[m_lock_ch] ? m_lock_ch : -1;
      for (int k = 0; k < N; k++) begin
         int c;
         c = (m_ptr + k) % N;
         if (in_valid[c]) return c;
      end
      return -1;
   endfunction

   task automatic test_reset();
      rst_n     = 1'b0;
      idle_inputs();
      mode      = 1'b1;
      in_valid  = '1;
      out_ready = 1'b1;
      #2;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
      checks++;
      if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
      checks++;
      if (out_ch !== '0) begin errors++; $display("FAIL reset_out_ch: got %0d expected 0", out_ch); end
      checks++;
      if (in_ready !== '0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== '0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_held: in_ready %b out_valid %0b expected 0000 0", in_ready, out_valid);
      end
   endtask

   task automatic test_fixed_select();
      apply_reset();
      mode      = 1'b0;
      sel       = 2'd2;
      in_valid  = 4'b1111;
      ramp_data();
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_in_ready: got %b expected 0100", in_ready); end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA2 || out_ch !== 2'd2) begin
         errors++;
         $display("FAIL fixed_out: got v%0b %h ch%0d expected v1 a2 ch2", out_valid, out_data, out_ch);
      end
      sel = 2'd1;
      in_valid = 4'b1101;
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin errors++; $display("FAIL fixed_invalid_sel: got %b expected 0000", in_ready); end
   endtask

   task automatic test_rr_fairness();
      apply_reset();
      mode      = 1'b1;
      in_valid  = 4'b1111;
      ramp_data();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_ch !== SW'(i % N) || out_data !== W'(8'hA0 + (i % N))) begin
            errors++;
            $display("FAIL rr_seq%0d: got ch%0d %h expected ch%0d %h", i, out_ch, out_data, i % N, 8'hA0 + (i % N));
         end
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      mode      = 1'b1;
      in_valid  = 4'b1111;
      ramp_data();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (in_ready !== '0) begin errors++; $display("FAIL bp_in_ready%0d: got %b expected 0000", i, in_ready); end
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'hA0 || out_ch !== 2'd0) begin
            errors++;
            $display("FAIL bp_hold%0d: got v%0b %h ch%0d expected v1 a0 ch0", i, out_valid, out_data, out_ch);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b expected 0010", in_ready); end
      @(posedge clk);
      #1;
      checks++;
      if (out_ch !== 2'd1 || out_data !== 8'hA1) begin
         errors++;
         $display("FAIL bp_release_out: got ch%0d %h expected ch1 a1", out_ch, out_data);
      end
   endtask

   task automatic test_skip_wrap();
      apply_reset();
      mode      = 1'b1;
      in_valid  = 4'b0100;
      ramp_data();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_ch !== 2'd2) begin errors++; $display("FAIL wrap_setup: got ch%0d expected ch2", out_ch); end
      in_valid = 4'b0010;
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin errors++; $display("FAIL wrap_grant: got %b expected 0010", in_ready); end
      @(posedge clk);
      #1;
      checks++;
      if (out_ch !== 2'd1 || out_data !== 8'hA1) begin
         errors++;
         $display("FAIL wrap_out: got ch%0d %h expected ch1 a1", out_ch, out_data);
      end
      in_valid = 4'b1111;
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin errors++; $display("FAIL wrap_ptr: got %b expected 0100", in_ready); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      mode      = 1'b1;
      in_valid  = 4'b1111;
      ramp_data();
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0) begin
         errors++;
         $display("FAIL async_clear: got v%0b %h ch%0d expected v0 00 ch0", out_valid, out_data, out_ch);
      end
      checks++;
      if (in_ready !== '0) begin errors++; $display("FAIL async_in_ready: got %b expected 0000", in_ready); end
      #3;
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin errors++; $display("FAIL async_first_grant: got %b expected 0001", in_ready); end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'hA0) begin
         errors++;
         $display("FAIL async_first_word: got v%0b ch%0d %h expected v1 ch0 a0", out_valid, out_ch, out_data);
      end
   endtask

`ifdef MUX_N_1_RR_PKT_LOCK_EN
   task automatic test_pkt_lock();
      apply_reset();
      mode      = 1'b1;
      ramp_data();
      out_ready = 1'b1;
      in_last   = 4'b1111;
      in_valid  = 4'b0001;
      @(posedge clk);
      #1;
      in_valid = 4'b0111;
      for (int b = 0; b < 3; b++) begin
         in_last = (b == 2) ? 4'b1111 : 4'b1101;
         @(posedge clk);
         #1;
         checks++;
         if (out_ch !== 2'd1) begin errors++; $display("FAIL lock_beat%0d: got ch%0d expected ch1", b, out_ch); end
      end
      in_last = 4'b1111;
      @(posedge clk);
      #1;
      checks++;
      if (out_ch !== 2'd2) begin errors++; $display("FAIL lock_after: got ch%0d expected ch2", out_ch); end
   endtask
`endif

   task automatic test_random();
      int g;
      bit load;
      logic [N-1:0] exp_rdy;
      logic [W-1:0] word;
      apply_reset();
      mode = 1'($urandom_range(0, 1));
      for (int cyc = 0; cyc < 400; cyc++) begin
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         sel       = SW'($urandom_range(0, N - 1));
         in_valid  = ($urandom_range(0, 3) == 0) ? '1 : N'($urandom_range(0, (1 << N) - 1));
         for (int k = 0; k < N; k++) in_data[k*W +: W] = W'($urandom_range(0, 255));
         out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_N_1_RR_PKT_LOCK_EN
         for (int k = 0; k < N; k++) in_last[k] = ($urandom_range(0, 2) != 0);
`endif
         #1;
         load    = (exp_q.size() == 0) || out_ready;
         g       = model_grant();
         exp_rdy = (load && g >= 0) ? N'(1 << g) : '0;
         checks++;
         if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL rand_in_ready c%0d: got %b expected %b", cyc, in_ready, exp_rdy);
         end
         checks++;
         if (out_valid !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL rand_out_valid c%0d: got %0b expected %0b", cyc, out_valid, exp_q.size() != 0);
         end
         if (exp_q.size() != 0) begin
            checks++;
            if ({out_ch, out_data} !== exp_q[0]) begin
               errors++;
               $display("FAIL rand_word c%0d: got ch%0d %h expected ch%0d %h", cyc, out_ch, out_data,
                        exp_q[0][SW+W-1:W], exp_q[0][W-1:0]);
            end
            if (out_ready) void'(exp_q.pop_front());
         end
         if (load && g >= 0) begin
            word = in_data[g*W +: W];
            exp_q.push_back({SW'(g), word});
            if (mode == 1'b1) begin
`ifdef MUX_N_1_RR_PKT_LOCK_EN
               if (in_last[g]) begin
                  m_ptr  = (g + 1) % N;
                  m_lock = 0;
               end else begin
                  m_lock    = 1;
                  m_lock_ch = g;
               end
`else
               m_ptr = (g + 1) % N;
`endif
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_fixed_select();
      test_rr_fairness();
      test_backpressure();
      test_skip_wrap();
      test_async_reset();
`ifdef MUX_N_1_RR_PKT_LOCK_EN
      test_pkt_lock();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_n_1_rr.md
MUX_N_1_RR -- requirements
Module: mux_n_1_rr

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of input channels, legal range 2..16.
REQ-002 SHALL have parameter DATA_W, default 8: payload width per channel, legal range 1..64.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port mode, input, 1: 0 = fixed select by sel, 1 = round-robin.
REQ-006 SHALL have port sel, input, SEL_W = clog2(N_CH): channel index used when mode=0.
REQ-007 SHALL have port in_valid, input, N_CH: per-channel valid.
REQ-008 SHALL have port in_data, input, N_CH*DATA_W: channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 SHALL have port in_ready, output, N_CH: per-channel ready; at most one bit high per cycle.
REQ-010 SHALL have port out_valid, output, 1: output register holds a word.
REQ-011 SHALL have port out_data, output, DATA_W: registered payload.
REQ-012 SHALL have port out_ch, output, SEL_W: source channel of out_data.
REQ-013 SHALL have port out_ready, input, 1: the downstream accepts the word.

Function
REQ-014 SHALL define load = !out_valid || out_ready; a channel transfers when in_valid[k] && in_ready[k].
REQ-015 SHALL assert in_ready[g] only when load=1 and g is the granted channel; in_ready is combinational from the current inputs and state.
REQ-016 SHALL grant in mode=0 channel sel if in_valid[sel]; if sel >= N_CH or in_valid[sel]=0, no channel is granted.
REQ-017 SHALL grant in mode=1 the first valid channel searching from rr_ptr upward, wrapping from N_CH-1 to 0.
REQ-018 SHALL set rr_ptr to (g+1) mod N_CH on a mode=1 transfer from channel g; otherwise rr_ptr holds.
REQ-019 SHALL leave rr_ptr unchanged by mode=0 transfers.
REQ-020 SHALL, on a transfer, load out_data/out_ch from channel g and set out_valid=1 the next cycle (latency 1).
REQ-021 SHALL clear out_valid when out_ready=1 and no transfer occurs in the same cycle.
REQ-022 SHALL sustain one word per cycle when out_ready is held high, with a simultaneous pop and load.
REQ-023 SHALL hold out_data, out_ch and out_valid stable while out_valid=1 && out_ready=0.
REQ-024 SHALL, when mode or sel changes while stalled, use the new value only on the next cycle with load=1.

Reset
REQ-025 SHALL, while rst_n=0, force out_valid=0, out_data=0, out_ch=0 and rr_ptr=0 immediately, independent of clk.
REQ-026 SHALL drop a word held in the output register when reset asserts; the word is not replayed.
REQ-027 SHALL hold in_ready all-zero while rst_n=0.

Configuration
REQ-028 SHALL support macro MUX_N_1_RR_PKT_LOCK_EN.
- Defined: adds input in_last (N_CH bits) and a lock register.
- In mode=1, after a transfer with in_last[g]=0, the grant stays on g until a transfer with in_last[g]=1.
- rr_ptr advances only after that last beat.
- Reset clears the lock.
- Undefined: no in_last port; arbitration is per word.

Structure
REQ-029 SHALL keep in shared package mux_n_1_pkg: mode encoding constants MODE_SEL=0 and MODE_RR=1, and the clog2-based SEL_W function.
REQ-030 SHALL place the round-robin grant logic in sub-module rr_arbiter: inputs are the request vector and pointer; output is a one-hot grant.

Verification
REQ-031 SHALL cover fixed select: mode=0, in_valid=4'b1111, data k=8'hA0+k, sel=2 -> out_data=8'hA2, out_ch=2, in_ready=4'b0100, one cycle later.
REQ-032 SHALL cover round-robin fairness: mode=1, all channels valid, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-033 SHALL cover backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data stable and in_ready=0; on release the next grant follows in the next cycle.
REQ-034 SHALL cover skip and wrap: mode=1, rr_ptr=3, in_valid=4'b0010 -> grant ch1, then rr_ptr=2.
REQ-035 SHALL cover async reset: rst_n pulsed low mid-stream between clock edges -> out_valid=0 immediately and the first grant after release is ch0.
REQ-036 SHALL, with MUX_N_1_RR_PKT_LOCK_EN, cover a 3-beat packet on ch1 with ch0 and ch2 valid -> out_ch 1,1,1, then 2.
